// File: rtl/relay_chain_stage.sv
// rtl/relay_chain_stage.sv - one registered hop of the relay chain
//
// Purpose: a single register slice between a valid/ready upstream and
// downstream. REG_READY=1 builds a 2-entry skid buffer whose ready, valid
// and data outputs all come straight from flops. REG_READY=0 builds a
// 1-entry pipeline register with combinational ready.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   valid_up, ready_up    upstream handshake (ready_up is an output)
//   data_up               upstream payload
//   valid_down, ready_down downstream handshake (valid_down is an output)
//   data_down             downstream payload

module relay_chain_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_READY  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_up,
    output logic                  ready_up,
    input  logic [DATA_WIDTH-1:0] data_up,
    output logic                  valid_down,
    input  logic                  ready_down,
    output logic [DATA_WIDTH-1:0] data_down
);

    generate
        if (REG_READY != 0) begin : g_skid
            (* keep = "true", dont_touch = "true" *) logic                  main_valid_q;
            (* keep = "true", dont_touch = "true" *) logic [DATA_WIDTH-1:0] main_data_q;
            (* keep = "true", dont_touch = "true" *) logic                  ready_q;
            logic                  skid_valid_q;
            logic [DATA_WIDTH-1:0] skid_data_q;
            logic                  accept;

            assign accept     = valid_up && ready_q;
            assign ready_up   = ready_q;
            assign valid_down = main_valid_q;
            assign data_down  = main_data_q;

            // ready_q tracks "skid will be empty after this edge". It is held
            // low through reset so nothing is accepted until the first edge
            // with reset released.
            always_ff @(posedge clk) begin
                if (reset) begin
                    main_valid_q <= 1'b0;
                    skid_valid_q <= 1'b0;
                    ready_q      <= 1'b0;
                end else if (!skid_valid_q) begin
                    if (!main_valid_q || ready_down) begin
                        main_valid_q <= accept;
                        ready_q      <= 1'b1;
                    end else begin
                        // Main is stalled: an accepted word parks in skid.
                        skid_valid_q <= accept;
                        ready_q      <= !accept;
                    end
                end else if (ready_down) begin
                    // Skid drains into main before any new word is taken.
                    skid_valid_q <= 1'b0;
                    ready_q      <= 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (!skid_valid_q) begin
                    if (!main_valid_q || ready_down) begin
                        if (accept) begin
                            main_data_q <= data_up;
                        end
                    end else if (accept) begin
                        skid_data_q <= data_up;
                    end
                end else if (ready_down) begin
                    main_data_q <= skid_data_q;
                end
            end
        end else begin : g_pipe
            (* keep = "true", dont_touch = "true" *) logic                  valid_q;
            (* keep = "true", dont_touch = "true" *) logic [DATA_WIDTH-1:0] data_q;

            assign ready_up   = !valid_q || ready_down;
            assign valid_down = valid_q;
            assign data_down  = data_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    valid_q <= 1'b0;
                end else if (ready_up) begin
                    valid_q <= valid_up;
                end
            end

            always_ff @(posedge clk) begin
                if (ready_up && valid_up) begin
                    data_q <= data_up;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/relay_chain.sv
// rtl/relay_chain.sv - LEVEL-deep chain of register slices with occupancy count
//
// Purpose: cuts a long FWFT-style write-to-read path into LEVEL registered
// hops and reports how many words are currently held in the chain.
// LEVEL=0 degenerates to a pure combinational passthrough.
//
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   if_full_n    write side may accept (ready)
//   if_write     write request (valid)
//   if_din       write data
//   if_empty_n   read data valid
//   if_read      read request (ready)
//   if_dout      read data, valid when if_empty_n=1
//   occupancy    words currently held in the chain

module relay_chain #(
    parameter int DATA_WIDTH  = 32,
    parameter int LEVEL       = 2,
    parameter int REG_READY   = 1,
    localparam int CAP        = LEVEL * ((REG_READY != 0) ? 2 : 1),
    localparam int OCC_WIDTH  = ($clog2(CAP + 1) > 1) ? $clog2(CAP + 1) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  if_full_n,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_empty_n,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic [OCC_WIDTH-1:0]  occupancy
);

    generate
        if (LEVEL == 0) begin : g_bypass
            assign if_full_n  = if_read;
            assign if_empty_n = if_write;
            assign if_dout    = if_din;
            assign occupancy  = '0;
        end else begin : g_chain
            // Node i is the link between stage i-1 and stage i; node 0 is the
            // write port and node LEVEL is the read port.
            logic [LEVEL:0]        valid_c;
            logic [LEVEL:0]        ready_c;
            logic [DATA_WIDTH-1:0] data_c [LEVEL+1];
            logic                  accept;
            logic                  deliver;
            logic [OCC_WIDTH-1:0]  occ_q;

            assign valid_c[0]     = if_write;
            assign data_c[0]      = if_din;
            assign if_full_n      = ready_c[0];
            assign ready_c[LEVEL] = if_read;
            assign if_empty_n     = valid_c[LEVEL];
            assign if_dout        = data_c[LEVEL];

            for (genvar i = 0; i < LEVEL; i++) begin : g_stage
                relay_chain_stage #(
                    .DATA_WIDTH (DATA_WIDTH),
                    .REG_READY  (REG_READY)
                ) u_stage (
                    .clk        (clk),
                    .reset      (reset),
                    .valid_up   (valid_c[i]),
                    .ready_up   (ready_c[i]),
                    .data_up    (data_c[i]),
                    .valid_down (valid_c[i+1]),
                    .ready_down (ready_c[i+1]),
                    .data_down  (data_c[i+1])
                );
            end

            assign accept    = if_write && if_full_n;
            assign deliver   = if_read && if_empty_n;
            assign occupancy = occ_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    occ_q <= '0;
                end else begin
                    case ({accept, deliver})
                        2'b10:   occ_q <= occ_q + 1'b1;
                        2'b01:   occ_q <= occ_q - 1'b1;
                        default: occ_q <= occ_q;
                    endcase
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_relay_chain.sv
// tb/tb_relay_chain.sv - self-checking bench for relay_chain

module tb_relay_chain;

    logic clk;
    logic reset;

    // LEVEL=2 skid chain for directed tests
    logic        a_write, a_read, a_full_n, a_empty_n;
    logic [31:0] a_din, a_dout;
    logic [2:0]  a_occ;

    // Random-stall chains: 0=L1 skid, 1=L3 skid, 2=L1 pipe, 3=L3 pipe
    logic        r_write   [4];
    logic        r_read    [4];
    logic        r_full_n  [4];
    logic        r_empty_n [4];
    logic [31:0] r_din     [4];
    logic [31:0] r_dout    [4];
    logic [1:0]  b_occ;
    logic [2:0]  c_occ;
    logic [0:0]  d_occ;
    logic [1:0]  e_occ;
    logic [31:0] r_occ     [4];

    // LEVEL=0 passthrough
    logic        f_write, f_read, f_full_n, f_empty_n;
    logic [31:0] f_din, f_dout;
    logic [0:0]  f_occ;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] seed;

    always_comb begin
        r_occ[0] = 32'(b_occ);
        r_occ[1] = 32'(c_occ);
        r_occ[2] = 32'(d_occ);
        r_occ[3] = 32'(e_occ);
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    relay_chain #(.DATA_WIDTH(32), .LEVEL(2), .REG_READY(1)) dut_a (
        .clk(clk), .reset(reset), .if_full_n(a_full_n), .if_write(a_write), .if_din(a_din),
        .if_empty_n(a_empty_n), .if_read(a_read), .if_dout(a_dout), .occupancy(a_occ));

    relay_chain #(.DATA_WIDTH(32), .LEVEL(1), .REG_READY(1)) dut_b (
        .clk(clk), .reset(reset), .if_full_n(r_full_n[0]), .if_write(r_write[0]), .if_din(r_din[0]),
        .if_empty_n(r_empty_n[0]), .if_read(r_read[0]), .if_dout(r_dout[0]), .occupancy(b_occ));

    relay_chain #(.DATA_WIDTH(32), .LEVEL(3), .REG_READY(1)) dut_c (
        .clk(clk), .reset(reset), .if_full_n(r_full_n[1]), .if_write(r_write[1]), .if_din(r_din[1]),
        .if_empty_n(r_empty_n[1]), .if_read(r_read[1]), .if_dout(r_dout[1]), .occupancy(c_occ));

    relay_chain #(.DATA_WIDTH(32), .LEVEL(1), .REG_READY(0)) dut_d (
        .clk(clk), .reset(reset), .if_full_n(r_full_n[2]), .if_write(r_write[2]), .if_din(r_din[2]),
        .if_empty_n(r_empty_n[2]), .if_read(r_read[2]), .if_dout(r_dout[2]), .occupancy(d_occ));

    relay_chain #(.DATA_WIDTH(32), .LEVEL(3), .REG_READY(0)) dut_e (
        .clk(clk), .reset(reset), .if_full_n(r_full_n[3]), .if_write(r_write[3]), .if_din(r_din[3]),
        .if_empty_n(r_empty_n[3]), .if_read(r_read[3]), .if_dout(r_dout[3]), .occupancy(e_occ));

    relay_chain #(.DATA_WIDTH(32), .LEVEL(0), .REG_READY(1)) dut_f (
        .clk(clk), .reset(reset), .if_full_n(f_full_n), .if_write(f_write), .if_din(f_din),
        .if_empty_n(f_empty_n), .if_read(f_read), .if_dout(f_dout), .occupancy(f_occ));

    // Payload for the n-th word written into a random-stall chain.
    function automatic logic [31:0] pat(input int n);
        return (32'(n) * 32'h9E3779B1) ^ seed;
    endfunction

    // Every task starts and ends just after a rising edge.
    task automatic test_reset();
        reset   = 1'b1;
        a_write = 1'b0; a_read = 1'b0; a_din = '0;
        f_write = 1'b0; f_read = 1'b0; f_din = '0;
        for (int j = 0; j < 4; j++) begin
            r_write[j] = 1'b0; r_read[j] = 1'b0; r_din[j] = '0;
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (a_full_n !== 1'b0) begin n_fail++; $display("FAIL reset_full_n: got %b want 0", a_full_n); end
            n_checks++;
            if (a_empty_n !== 1'b0) begin n_fail++; $display("FAIL reset_empty_n: got %b want 0", a_empty_n); end
            n_checks++;
            if (a_occ !== 3'd0) begin n_fail++; $display("FAIL reset_occ: got %0d want 0", a_occ); end
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (a_full_n !== 1'b0) begin n_fail++; $display("FAIL release_full_n_early: got %b want 0", a_full_n); end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (a_full_n !== 1'b1) begin n_fail++; $display("FAIL release_full_n: got %b want 1", a_full_n); end
        n_checks++;
        if (a_empty_n !== 1'b0) begin n_fail++; $display("FAIL idle_empty_n: got %b want 0", a_empty_n); end
        n_checks++;
        if (a_occ !== 3'd0) begin n_fail++; $display("FAIL idle_occ: got %0d want 0", a_occ); end
        @(posedge clk); #1;
    endtask

    task automatic test_stream();
        int  sent = 0, got = 0, first_acc = -1, first_val = -1;
        logic acc, del;
        a_read = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            a_write = (sent < 16);
            a_din   = 32'(sent + 1);
            @(negedge clk);
            if (a_write) begin
                n_checks++;
                if (a_full_n !== 1'b1) begin n_fail++; $display("FAIL stream_full_n cyc %0d: got %b want 1", cyc, a_full_n); end
            end
            n_checks++;
            if (32'(a_occ) !== 32'(sent - got)) begin
                n_fail++; $display("FAIL stream_occ cyc %0d: got %0d want %0d", cyc, a_occ, sent - got);
            end
            if (a_empty_n === 1'b1) begin
                if (first_val < 0) first_val = cyc;
                n_checks++;
                if (a_dout !== 32'(got + 1)) begin
                    n_fail++; $display("FAIL stream_data: got %h want %h", a_dout, 32'(got + 1));
                end
                n_checks++;
                if (cyc !== first_val + got) begin
                    n_fail++; $display("FAIL stream_gap: word %0d at cyc %0d want %0d", got, cyc, first_val + got);
                end
            end
            acc = a_write && a_full_n;
            del = a_read && a_empty_n;
            if (acc && first_acc < 0) first_acc = cyc;
            @(posedge clk); #1;
            sent += int'(acc);
            got  += int'(del);
        end
        a_write = 1'b0;
        a_read  = 1'b0;
        n_checks++;
        if (got !== 16) begin n_fail++; $display("FAIL stream_count: got %0d want 16", got); end
        n_checks++;
        if (first_val - first_acc !== 2) begin
            n_fail++; $display("FAIL stream_latency: got %0d want 2", first_val - first_acc);
        end
    endtask

    task automatic test_fill();
        int  acc_n = 0;
        logic acc;
        a_read  = 1'b0;
        a_write = 1'b1;
        a_din   = 32'd0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            acc = a_full_n;
            @(posedge clk); #1;
            if (acc) begin
                acc_n++;
                a_din = 32'(acc_n);
            end
        end
        a_write = 1'b0;
        @(negedge clk);
        n_checks++;
        if (acc_n !== 4) begin n_fail++; $display("FAIL fill_accepted: got %0d want 4", acc_n); end
        n_checks++;
        if (a_full_n !== 1'b0) begin n_fail++; $display("FAIL fill_full_n: got %b want 0", a_full_n); end
        n_checks++;
        if (a_occ !== 3'd4) begin n_fail++; $display("FAIL fill_occ: got %0d want 4", a_occ); end
        @(posedge clk); #1;
        a_read = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (a_empty_n !== 1'b1 || a_dout !== 32'(i)) begin
                n_fail++; $display("FAIL drain_word %0d: got valid %b data %h want valid 1 data %h", i, a_empty_n, a_dout, 32'(i));
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        n_checks++;
        if (a_full_n !== 1'b1) begin n_fail++; $display("FAIL drain_full_n: got %b want 1", a_full_n); end
        n_checks++;
        if (a_empty_n !== 1'b0 || a_occ !== 3'd0) begin
            n_fail++; $display("FAIL drain_empty: got valid %b occ %0d want 0 0", a_empty_n, a_occ);
        end
        @(posedge clk); #1;
        a_read = 1'b0;
    endtask

    task automatic test_reset_mid();
        int  acc_n = 0;
        logic acc;
        logic got;
        logic [31:0] words [3];
        words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33;
        a_read = 1'b0;
        for (int k = 0; k < 10 && acc_n < 3; k++) begin
            a_write = 1'b1;
            a_din   = words[acc_n];
            @(negedge clk);
            acc = a_full_n;
            @(posedge clk); #1;
            if (acc) acc_n++;
        end
        a_write = 1'b0;
        @(negedge clk);
        n_checks++;
        if (a_occ !== 3'd3) begin n_fail++; $display("FAIL mid_preload_occ: got %0d want 3", a_occ); end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (a_empty_n !== 1'b0) begin n_fail++; $display("FAIL mid_reset_empty_n: got %b want 0", a_empty_n); end
        n_checks++;
        if (a_occ !== 3'd0) begin n_fail++; $display("FAIL mid_reset_occ: got %0d want 0", a_occ); end
        @(posedge clk); #1;
        a_write = 1'b1;
        a_din   = 32'hA5A5A5A5;
        acc     = 1'b0;
        for (int k = 0; k < 8 && !acc; k++) begin
            @(negedge clk);
            acc = a_full_n;
            @(posedge clk); #1;
        end
        a_write = 1'b0;
        a_din   = 32'h0;
        n_checks++;
        if (acc !== 1'b1) begin n_fail++; $display("FAIL mid_write_timeout: got %b want 1", acc); end
        a_read = 1'b1;
        got    = 1'b0;
        for (int k = 0; k < 8 && !got; k++) begin
            @(negedge clk);
            if (a_empty_n === 1'b1) begin
                got = 1'b1;
                n_checks++;
                if (a_dout !== 32'hA5A5A5A5) begin
                    n_fail++; $display("FAIL mid_first_read: got %h want a5a5a5a5", a_dout);
                end
            end
            @(posedge clk); #1;
        end
        a_read = 1'b0;
        n_checks++;
        if (got !== 1'b1) begin n_fail++; $display("FAIL mid_read_timeout: got %b want 1", got); end
        @(negedge clk);
        n_checks++;
        if (a_occ !== 3'd0 || a_empty_n !== 1'b0) begin
            n_fail++; $display("FAIL mid_stale: got occ %0d valid %b want 0 0", a_occ, a_empty_n);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_passthrough();
        f_write = 1'b1;
        f_din   = 32'hDEADBEEF;
        f_read  = 1'b0;
        @(negedge clk);
        n_checks++;
        if (f_empty_n !== 1'b1 || f_dout !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL pass_data: got valid %b data %h want 1 deadbeef", f_empty_n, f_dout);
        end
        n_checks++;
        if (f_full_n !== 1'b0) begin n_fail++; $display("FAIL pass_full_n: got %b want 0", f_full_n); end
        n_checks++;
        if (f_occ !== 1'b0) begin n_fail++; $display("FAIL pass_occ: got %0d want 0", f_occ); end
        @(posedge clk); #1;
        f_write = 1'b0;
        f_read  = 1'b1;
        @(negedge clk);
        n_checks++;
        if (f_full_n !== 1'b1 || f_empty_n !== 1'b0) begin
            n_fail++; $display("FAIL pass_ready: got full_n %b empty_n %b want 1 0", f_full_n, f_empty_n);
        end
        @(posedge clk); #1;
        f_read = 1'b0;
    endtask

    task automatic test_random_stall();
        int   wr  [4];
        int   rd  [4];
        int   cap [4];
        logic acc [4];
        logic del [4];
        cap[0] = 2; cap[1] = 6; cap[2] = 1; cap[3] = 3;
        for (int j = 0; j < 4; j++) begin
            wr[j] = 0; rd[j] = 0;
        end
        seed = $urandom;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int j = 0; j < 4; j++) begin
                r_write[j] = 1'($urandom_range(0, 1));
                r_read[j]  = 1'($urandom_range(0, 1));
                r_din[j]   = r_write[j] ? pat(wr[j]) : $urandom;
            end
            @(negedge clk);
            for (int j = 0; j < 4; j++) begin
                n_checks++;
                if (r_occ[j] !== 32'(wr[j] - rd[j]) || wr[j] - rd[j] > cap[j]) begin
                    n_fail++; $display("FAIL rand_occ[%0d] cyc %0d: got %0d want %0d (cap %0d)", j, cyc, r_occ[j], wr[j] - rd[j], cap[j]);
                end
                if (r_empty_n[j] === 1'b1) begin
                    n_checks++;
                    if (wr[j] == rd[j] || r_dout[j] !== pat(rd[j])) begin
                        n_fail++; $display("FAIL rand_data[%0d] cyc %0d: got %h want %h (held %0d)", j, cyc, r_dout[j], pat(rd[j]), wr[j] - rd[j]);
                    end
                end
                acc[j] = r_write[j] && (r_full_n[j] === 1'b1);
                del[j] = r_read[j] && (r_empty_n[j] === 1'b1);
            end
            @(posedge clk); #1;
            for (int j = 0; j < 4; j++) begin
                wr[j] += int'(acc[j]);
                rd[j] += int'(del[j]);
            end
        end
        for (int j = 0; j < 4; j++) begin
            r_write[j] = 1'b0;
            r_read[j]  = 1'b0;
            n_checks++;
            if (rd[j] < 1000) begin
                n_fail++; $display("FAIL rand_progress[%0d]: got %0d reads want >= 1000", j, rd[j]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_fill();
        test_reset_mid();
        test_passthrough();
        test_random_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
